// File: rtl/program_loader_pkg.sv
// Shared constants, state encoding and small helpers for the program loader
// and the program memory it feeds.
package program_loader_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         CMD_CNT_DEF  = 64;
  localparam int         PC_WIDTH_DEF = 8;
  localparam int         IR_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CHK   = 3'd4,
    ST_CLEAR = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  // States in which the loader takes a stream byte.
  function automatic logic st_accepts(input state_t st);
    logic acc;
    case (st)
      ST_IDLE, ST_LEN, ST_HI, ST_LO, ST_CHK: acc = 1'b1;
      default:                               acc = 1'b0;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream (valid/ready) plus program memory write port of the loader.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int IRWidth  = IR_WIDTH_DEF
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                mem_we;
  logic [PC_WIDTH-1:0] mem_addr;
  logic [IRWidth-1:0]  mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader_fsm_ctrl.sv
// Frame parser: state register, word index and checksum accumulator.
// Produces a combinational write request that the top level registers.
module loader_fsm_ctrl
  import program_loader_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int IRWidth  = IR_WIDTH_DEF,
  parameter int CMD_CNT  = CMD_CNT_DEF
)
(
  input  logic                clk,
  input  logic                res,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                restart,
  output logic                wr_req,
  output logic [PC_WIDTH-1:0] wr_addr,
  output logic [IRWidth-1:0]  wr_data,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

  localparam logic [PC_WIDTH-1:0] LAST_ADDR = PC_WIDTH'(CMD_CNT - 1);

  state_t              state_r, state_next;
  logic [PC_WIDTH-1:0] index_r, index_next;
  logic [PC_WIDTH-1:0] n_r, n_next;
  logic [7:0]          acc_r, acc_next;
  logic [7:0]          hi_r, hi_next;
  logic                in_ready_r, done_r, err_r, hold_r;
  logic                accept_s, len_bad_s, full_s, last_word_s;
  logic                wr_req_s;
  logic [PC_WIDTH-1:0] wr_addr_s;
  logic [IRWidth-1:0]  wr_data_s;

  assign accept_s    = in_valid && in_ready_r;
  assign len_bad_s   = (in_data == 8'd0) || ({24'd0, in_data} > 32'(CMD_CNT));
  assign full_s      = (32'(n_r) == 32'(CMD_CNT));
  assign last_word_s = ((index_r + PC_WIDTH'(1)) == n_r);

  // Next-state, datapath updates and write request.
  always_comb begin
    state_next = state_r;
    index_next = index_r;
    n_next     = n_r;
    acc_next   = acc_r;
    hi_next    = hi_r;
    wr_req_s   = 1'b0;
    wr_addr_s  = index_r;
    wr_data_s  = {IRWidth{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (in_data == SYNC_BYTE)) begin
          state_next = ST_LEN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          if (len_bad_s) begin
            state_next = ST_ERR;
          end else begin
            n_next     = PC_WIDTH'(in_data);
            index_next = '0;
            acc_next   = 8'd0;
            state_next = ST_HI;
          end
        end else begin
          state_next = ST_LEN;
        end
      end
      ST_HI: begin
        if (accept_s) begin
          hi_next    = in_data;
          acc_next   = chk_fold(acc_r, in_data);
          state_next = ST_LO;
        end else begin
          state_next = ST_HI;
        end
      end
      ST_LO: begin
        if (accept_s) begin
          acc_next   = chk_fold(acc_r, in_data);
          wr_req_s   = 1'b1;
          wr_data_s  = IRWidth'({hi_r, in_data});
          index_next = index_r + PC_WIDTH'(1);
          if (last_word_s) begin
            state_next = ST_CHK;
          end else begin
            state_next = ST_HI;
          end
        end else begin
          state_next = ST_LO;
        end
      end
      ST_CHK: begin
        if (accept_s) begin
          if (in_data != acc_r) begin
            state_next = ST_ERR;
          end else if (full_s) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_CLEAR;
          end
        end else begin
          state_next = ST_CHK;
        end
      end
      // index already points at N after the last word; sweep it to the top.
      ST_CLEAR: begin
        wr_req_s = 1'b1;
        if (index_r == LAST_ADDR) begin
          state_next = ST_DONE;
        end else begin
          index_next = index_r + PC_WIDTH'(1);
          state_next = ST_CLEAR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (restart) begin
          index_next = '0;
          state_next = ST_IDLE;
        end else begin
          state_next = state_r;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, datapath and status flag registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r    <= ST_IDLE;
      index_r    <= '0;
      n_r        <= '0;
      acc_r      <= 8'd0;
      hi_r       <= 8'd0;
      in_ready_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      hold_r     <= 1'b1;
    end else begin
      state_r    <= state_next;
      index_r    <= index_next;
      n_r        <= n_next;
      acc_r      <= acc_next;
      hi_r       <= hi_next;
      in_ready_r <= st_accepts(state_next);
      done_r     <= (state_next == ST_DONE);
      err_r      <= (state_next == ST_ERR);
      hold_r     <= (state_next != ST_DONE);
    end
  end

  assign in_ready = in_ready_r;
  assign wr_req   = wr_req_s;
  assign wr_addr  = wr_addr_s;
  assign wr_data  = wr_data_s;
  assign cpu_hold = hold_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: rtl/program_loader.sv
// Program memory writer: parses the framed byte stream and drives a
// registered write port; releases the CPU only after a verified image.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int IRWidth  = IR_WIDTH_DEF,
  parameter int CMD_CNT  = CMD_CNT_DEF
)
(
  input  logic              clk,
  input  logic              res,
  program_loader_if.slave   bus,
  input  logic              restart,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  logic                wr_req_s;
  logic [PC_WIDTH-1:0] wr_addr_s;
  logic [IRWidth-1:0]  wr_data_s;
  logic                in_ready_s;
  logic                mem_we_r;
  logic [PC_WIDTH-1:0] mem_addr_r;
  logic [IRWidth-1:0]  mem_wdata_r;

  loader_fsm_ctrl #(
    .PC_WIDTH (PC_WIDTH),
    .IRWidth  (IRWidth),
    .CMD_CNT  (CMD_CNT)
  ) u_ctrl (
    .clk      (clk),
    .res      (res),
    .in_data  (bus.in_data),
    .in_valid (bus.in_valid),
    .in_ready (in_ready_s),
    .restart  (restart),
    .wr_req   (wr_req_s),
    .wr_addr  (wr_addr_s),
    .wr_data  (wr_data_s),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  // Write port register; address and data hold between strobes.
  always_ff @(posedge clk) begin
    if (res) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      mem_we_r <= wr_req_s;
      if (wr_req_s) begin
        mem_addr_r  <= wr_addr_s;
        mem_wdata_r <= wr_data_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule
